// File: rtl/wasm_pkg.sv
// Shared opcodes, trap codes and FSM state type for the wasm_cpu core.
// Define WASM_CPU_I64_EN to widen stack entries to 64 bits and enable i64.const.
package wasm_pkg;

    localparam int unsigned MEM_EXTRA = 4;

`ifdef WASM_CPU_I64_EN
    localparam int unsigned DATA_W = 64;
`else
    localparam int unsigned DATA_W = 32;
`endif

    localparam logic [7:0] OpUnreachable = 8'h00;
    localparam logic [7:0] OpNop         = 8'h01;
    localparam logic [7:0] OpEnd         = 8'h0B;
    localparam logic [7:0] OpDrop        = 8'h1A;
    localparam logic [7:0] OpSelect      = 8'h1B;
    localparam logic [7:0] OpI32Const    = 8'h41;
    localparam logic [7:0] OpI64Const    = 8'h42;
    localparam logic [7:0] OpI32Eqz      = 8'h45;
    localparam logic [7:0] OpI32Add      = 8'h6A;
    localparam logic [7:0] OpI32Sub      = 8'h6B;

    localparam logic [3:0] TrapNone        = 4'd0;
    localparam logic [3:0] TrapUnreachable = 4'd1;
    localparam logic [3:0] TrapUnderflow   = 4'd2;
    localparam logic [3:0] TrapOverflow    = 4'd3;
    localparam logic [3:0] TrapInvalid     = 4'd4;
    localparam logic [3:0] TrapMemory      = 4'd5;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt,
        StTrap
    } state_e;

endpackage

// File: rtl/leb128_decoder.sv
// Combinational signed LEB128 decoder for the bytes following the opcode.
// Produces the sign-extended value, encoded length and an unterminated flag.
module leb128_decoder (
    input  logic [119:0] bytes_i,
    input  logic         is_64_i,
    output logic [63:0]  value_o,
    output logic [3:0]   len_o,
    output logic         err_o
);

    logic [69:0] raw;
    logic        found;
    logic        sign;
    int          nbits;
    int          max_bytes;
    logic        unused_bits;

    always_comb begin
        raw       = '0;
        len_o     = '0;
        found     = 1'b0;
        sign      = 1'b0;
        nbits     = 0;
        max_bytes = is_64_i ? 10 : 5;
        for (int i = 0; i < 10; i++) begin
            if (!found && (i < max_bytes)) begin
                raw[7*i +: 7] = bytes_i[8*i +: 7];
                if (!bytes_i[8*i+7]) begin
                    found = 1'b1;
                    len_o = 4'(i + 1);
                    sign  = bytes_i[8*i+6];
                    nbits = 7 * (i + 1);
                end
            end
        end
        for (int b = 0; b < 70; b++) begin
            if (b >= nbits) begin
                raw[b] = sign;
            end
        end
        // i32 immediates wrap to 32 bits before sign extension.
        value_o = is_64_i ? raw[63:0] : {{32{raw[31]}}, raw[31:0]};
        err_o   = !found;
    end

    assign unused_bits = ^{bytes_i[119:80], raw[69:64]};

endmodule

// File: rtl/wasm_cpu.sv
// WebAssembly stack-machine core: two-cycle FETCH/EXEC over a 16-byte ROM window.
// Define WASM_CPU_I64_EN for 64-bit stack entries and i64.const support.
module wasm_cpu
    import wasm_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 4,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [63:0]          result,
    output logic                 result_empty,
    output logic [3:0]           trap,
    output logic [MEM_DEPTH:0]   mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    input  logic [127:0]         mem_data,
    input  logic                 mem_error
);

    localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned PcW  = MEM_DEPTH + 1;

    state_e            state_q, state_d;
    logic [PcW-1:0]    pc_q, pc_d;
    logic [SpW-1:0]    sp_q, sp_d;
    logic [63:0]       result_q, result_d;
    logic              empty_q, empty_d;
    logic [3:0]        trap_q, trap_d;
    logic [DATA_W-1:0] stack_q [STACK_DEPTH];

    logic [7:0]        opcode;
    logic [63:0]       imm;
    logic [3:0]        imm_len;
    logic              imm_err;
    logic              is_64;
    logic [1:0]        n_pop;
    logic              do_push;
    logic [DATA_W-1:0] push_val;
    logic [31:0]       alu32;
    logic [3:0]        fault;
    logic              halt;
    logic [PcW-1:0]    pc_inc;
    logic [DATA_W-1:0] op_a, op_b, op_c;
    logic [DATA_W-1:0] new_top;
    logic              push_we;
    logic [IdxW-1:0]   wr_idx;
    logic              unused_bits;

    assign opcode = mem_data[7:0];
    assign is_64  = (opcode == OpI64Const);

    leb128_decoder u_leb (
        .bytes_i (mem_data[127:8]),
        .is_64_i (is_64),
        .value_o (imm),
        .len_o   (imm_len),
        .err_o   (imm_err)
    );

    // op_c is the top of stack, op_b below it, op_a below that.
    assign op_c = stack_q[IdxW'(sp_q - SpW'(1))];
    assign op_b = stack_q[IdxW'(sp_q - SpW'(2))];
    assign op_a = stack_q[IdxW'(sp_q - SpW'(3))];
    assign unused_bits = ^{imm, op_c};

    always_comb begin
        n_pop    = 2'd0;
        do_push  = 1'b0;
        push_val = '0;
        fault    = TrapNone;
        halt     = 1'b0;
        pc_inc   = PcW'(1);
        alu32    = (opcode == OpI32Sub) ? (op_b[31:0] - op_c[31:0]) : (op_b[31:0] + op_c[31:0]);
        case (opcode)
            OpUnreachable: fault = TrapUnreachable;
            OpNop:         ;
            OpEnd:         halt = 1'b1;
            OpDrop:        n_pop = 2'd1;
            OpSelect: begin
                n_pop    = 2'd3;
                do_push  = 1'b1;
                push_val = (op_c[31:0] != 32'd0) ? op_a : op_b;
            end
            OpI32Const: begin
                do_push  = 1'b1;
                push_val = DATA_W'(imm[31:0]);
                pc_inc   = PcW'(imm_len) + PcW'(1);
                if (imm_err) fault = TrapInvalid;
            end
`ifdef WASM_CPU_I64_EN
            OpI64Const: begin
                do_push  = 1'b1;
                push_val = imm[DATA_W-1:0];
                pc_inc   = PcW'(imm_len) + PcW'(1);
                if (imm_err) fault = TrapInvalid;
            end
`endif
            OpI32Eqz: begin
                n_pop    = 2'd1;
                do_push  = 1'b1;
                push_val = DATA_W'(op_c[31:0] == 32'd0);
            end
            OpI32Add, OpI32Sub: begin
                n_pop    = 2'd2;
                do_push  = 1'b1;
                push_val = DATA_W'(alu32);
            end
            default: fault = TrapInvalid;
        endcase
        if (fault == TrapNone) begin
            if (SpW'(n_pop) > sp_q) begin
                fault = TrapUnderflow;
            end else if (do_push && ((sp_q - SpW'(n_pop)) == SpW'(STACK_DEPTH))) begin
                fault = TrapOverflow;
            end
        end
        if (mem_error) fault = TrapMemory;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            sp_q     <= '0;
            result_q <= '0;
            empty_q  <= 1'b1;
            trap_q   <= TrapNone;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            result_q <= result_d;
            empty_q  <= empty_d;
            trap_q   <= trap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_we) stack_q[wr_idx] <= push_val;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        result_d = result_q;
        empty_d  = empty_q;
        trap_d   = trap_q;
        push_we  = 1'b0;
        wr_idx   = IdxW'(sp_q - SpW'(n_pop));
        new_top  = '0;
        unique case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                if (fault != TrapNone) begin
                    state_d = StTrap;
                    trap_d  = fault;
                end else if (halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                    pc_d    = pc_q + pc_inc;
                    sp_d    = sp_q - SpW'(n_pop) + SpW'(do_push);
                    push_we = do_push;
                    if (do_push) begin
                        new_top = push_val;
                    end else if (sp_d != '0) begin
                        new_top = stack_q[IdxW'(sp_d - SpW'(1))];
                    end
                    result_d = 64'(new_top);
                    empty_d  = (sp_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr     = pc_q;
        mem_extra    = {MEM_EXTRA{1'b1}};
        result       = result_q;
        result_empty = empty_q;
        trap         = trap_q;
    end

endmodule

// File: tb/tb_wasm_cpu.sv
// Self-checking bench for wasm_cpu: directed programs plus random programs
// compared against a queue-based interpreter of the instruction set.
module tb_wasm_cpu;

    localparam int MemDepth = 6;
    localparam int Depth    = 8;
    localparam int RomSize  = 1 << (MemDepth + 1);
`ifdef WASM_CPU_I64_EN
    localparam bit I64 = 1'b1;
`else
    localparam bit I64 = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [63:0]     result;
    logic            result_empty;
    logic [3:0]      trap;
    logic [MemDepth:0] mem_addr;
    logic [3:0]      mem_extra;
    logic [127:0]    mem_data = '0;
    logic            mem_error = 1'b0;

    logic [7:0]      rom [RomSize];
    logic [7:0]      prog [$];
    int              n_checks = 0;
    int              n_errors = 0;

    wasm_cpu #(
        .MEM_DEPTH   (MemDepth),
        .STACK_DEPTH (Depth)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_empty (result_empty),
        .trap         (trap),
        .mem_addr     (mem_addr),
        .mem_extra    (mem_extra),
        .mem_data     (mem_data),
        .mem_error    (mem_error)
    );

    always #5 clk = ~clk;

    // Registered-read ROM with a 16-byte window.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            mem_data[8*i +: 8] <= (int'(mem_addr) + i < RomSize) ? rom[int'(mem_addr) + i] : 8'h00;
        end
        mem_error <= (int'(mem_addr) + 15 >= RomSize);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void leb(input int at, input int maxb, output logic [63:0] val,
                                output int len, output bit ok);
        int shift = 0;
        logic [7:0] b;
        val = '0;
        len = 0;
        ok  = 1'b0;
        for (int i = 0; i < maxb && !ok; i++) begin
            b     = rom[at + i];
            val   = val | ({57'd0, b[6:0]} << shift);
            shift += 7;
            len++;
            if (!b[7]) begin
                ok = 1'b1;
                if (b[6] && shift < 64) val = val | (~64'd0 << shift);
            end
        end
    endfunction

    // Interprets the ROM; n is the number of instructions executed including the last.
    function automatic void model_run(output logic [63:0] res, output logic emp,
                                      output logic [3:0] trp, output int n);
        logic [63:0] stk [$];
        logic [63:0] a, b, c, v;
        logic [31:0] s32;
        logic [7:0]  op;
        int          pc, len;
        bit          ok, done;
        pc = 0; n = 0; trp = 4'd0; done = 1'b0;
        while (!done) begin
            n++;
            op = rom[pc];
            if (pc + 15 >= RomSize) trp = 4'd5;
            else case (op)
                8'h00: trp = 4'd1;
                8'h01: pc++;
                8'h0B: done = 1'b1;
                8'h1A: if (stk.size() < 1) trp = 4'd2;
                       else begin void'(stk.pop_back()); pc++; end
                8'h1B: if (stk.size() < 3) trp = 4'd2;
                       else begin
                           c = stk.pop_back(); b = stk.pop_back(); a = stk.pop_back();
                           stk.push_back((c[31:0] != 0) ? a : b); pc++;
                       end
                8'h41, 8'h42: begin
                    if (op == 8'h42 && !I64) trp = 4'd4;
                    else begin
                        leb(pc + 1, (op == 8'h42) ? 10 : 5, v, len, ok);
                        if (!ok) trp = 4'd4;
                        else if (stk.size() == Depth) trp = 4'd3;
                        else begin
                            stk.push_back((op == 8'h42) ? v : {32'd0, v[31:0]});
                            pc += 1 + len;
                        end
                    end
                end
                8'h45: if (stk.size() < 1) trp = 4'd2;
                       else begin
                           v = stk.pop_back(); stk.push_back((v[31:0] == 0) ? 64'd1 : 64'd0); pc++;
                       end
                8'h6A, 8'h6B: if (stk.size() < 2) trp = 4'd2;
                       else begin
                           c = stk.pop_back(); a = stk.pop_back();
                           s32 = (op == 8'h6A) ? a[31:0] + c[31:0] : a[31:0] - c[31:0];
                           stk.push_back({32'd0, s32}); pc++;
                       end
                default: trp = 4'd4;
            endcase
            if (trp != 0) done = 1'b1;
        end
        emp = (stk.size() == 0);
        res = emp ? 64'd0 : stk[stk.size() - 1];
    endfunction

    task automatic load(input logic [7:0] p [$], input logic [7:0] fill);
        foreach (rom[i]) rom[i] = fill;
        foreach (p[i]) rom[i] = p[i];
    endtask

    // Pulses reset, then checks trap timing, final outputs and stickiness.
    task automatic run_and_check(input string tag);
        logic [63:0] er;
        logic        ee;
        logic [3:0]  et;
        int          n;
        model_run(er, ee, et, n);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2 * n - 1) @(posedge clk);
        #1;
        if (et != 0) check_eq({tag, "_trap_early"}, 64'(trap), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_result"}, result, er);
        check_eq({tag, "_empty"}, 64'(result_empty), 64'(ee));
        check_eq({tag, "_trap"}, 64'(trap), 64'(et));
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_sticky"}, {result[59:0], trap}, {er[59:0], et});
    endtask

    task automatic gen_random();
        int pc = 0;
        int r, nb;
        int nins = $urandom_range(1, 30);
        foreach (rom[i]) rom[i] = 8'($urandom);
        for (int k = 0; k < nins && pc < 100; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                rom[pc] = (r < 4) ? 8'h42 : 8'h41;
                pc++;
                nb = $urandom_range(1, 6);
                for (int j = 0; j < nb; j++) begin
                    rom[pc] = 8'($urandom_range(0, 127));
                    if (j != nb - 1 || nb == 6) rom[pc][7] = 1'b1;
                    pc++;
                end
            end else begin
                if      (r < 50) rom[pc] = 8'h01;
                else if (r < 60) rom[pc] = 8'h1A;
                else if (r < 70) rom[pc] = 8'h1B;
                else if (r < 78) rom[pc] = 8'h45;
                else if (r < 86) rom[pc] = 8'h6A;
                else if (r < 94) rom[pc] = 8'h6B;
                else if (r < 96) rom[pc] = 8'h00;
                else             rom[pc] = 8'($urandom_range(8'h70, 8'hFF));
                pc++;
            end
        end
        rom[pc] = 8'h0B;
    endtask

    initial begin
        foreach (rom[i]) rom[i] = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_empty", 64'(result_empty), 64'd1);
        check_eq("rst_trap", 64'(trap), 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_extra", 64'(mem_extra), 64'd15);

        prog = '{8'h41, 8'h01, 8'h41, 8'h02, 8'h41, 8'h01, 8'h1B, 8'h0B};
        load(prog, 8'h00); run_and_check("sel1");
        check_eq("sel1_const", result, 64'd1);
        prog = '{8'h41, 8'h01, 8'h41, 8'h02, 8'h41, 8'h00, 8'h1B, 8'h0B};
        load(prog, 8'h00); run_and_check("sel0");
        check_eq("sel0_const", result, 64'd2);
        prog = '{8'h41, 8'hFF, 8'h00, 8'h41, 8'h03, 8'h6A, 8'h0B};
        load(prog, 8'h00); run_and_check("add");
        check_eq("add_const", result, 64'd130);
        prog = '{8'h41, 8'h7F, 8'h45, 8'h0B};
        load(prog, 8'h00); run_and_check("eqz");
        check_eq("eqz_const", result, 64'd0);
        prog = '{8'h0B};
        load(prog, 8'h00); run_and_check("end");
        check_eq("end_empty", 64'(result_empty), 64'd1);
        prog = '{8'h00};
        load(prog, 8'h00); run_and_check("unreach");
        check_eq("unreach_code", 64'(trap), 64'd1);
        prog = '{8'h1A, 8'h0B};
        load(prog, 8'h00); run_and_check("under");
        check_eq("under_code", 64'(trap), 64'd2);
        prog = '{8'hFF};
        load(prog, 8'h00); run_and_check("inval");
        check_eq("inval_code", 64'(trap), 64'd4);
        prog = '{8'h42, 8'h7F, 8'h0B};
        load(prog, 8'h00); run_and_check("i64");
        check_eq("i64_const", {result[59:0], trap},
                 I64 ? {60'hFFF_FFFF_FFFF_FFFF, 4'd0} : {60'd0, 4'd4});
        prog = '{};
        for (int i = 0; i < 9; i++) begin prog.push_back(8'h41); prog.push_back(8'h05); end
        load(prog, 8'h0B); run_and_check("over");
        check_eq("over_code", 64'(trap), 64'd3);
        prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0B};
        load(prog, 8'h0B); run_and_check("leb_unterm");
        prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0F, 8'h0B};
        load(prog, 8'h00); run_and_check("leb_5byte");
        check_eq("leb_5byte_const", result, 64'hF000_0000);
        prog = '{};
        load(prog, 8'h01); run_and_check("memerr");
        check_eq("memerr_code", 64'(trap), 64'd5);

        // Asynchronous reset in the middle of a running program.
        prog = '{8'h41, 8'h05, 8'h41, 8'h06, 8'h6A, 8'h41, 8'h07, 8'h6B, 8'h0B};
        load(prog, 8'h00);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_before", result, 64'd6);
        #3;
        reset = 1'b0;
        #1;
        check_eq("mid_rst", {result[58:0], result_empty, trap}, {59'd0, 1'b1, 4'd0});
        check_eq("mid_addr", {60'(mem_addr), mem_extra}, {60'd0, 4'd15});
        run_and_check("mid_rerun");
        check_eq("mid_rerun_const", result, 64'd4);

        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_and_check($sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
